// File: rtl/fir_decim_if.sv
// Sample/result bus for the FIR decimator.
// master: drives samples and the result-ready strobe, observes results.
// slave : the decimator itself.
//   in_valid  - x_in carries an accepted sample this cycle
//   x_in      - signed sample from the upstream FIR
//   out_ready - consumer takes y_out this cycle
//   y_out     - signed, rounded window average
//   out_valid - y_out holds an unconsumed result
//   overrun   - sticky: a result was overwritten before being consumed
interface fir_decim_if #(
    parameter int DATA_W = 8
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] x_in;
    logic                     out_ready;
    logic signed [DATA_W-1:0] y_out;
    logic                     out_valid;
    logic                     overrun;

    modport master (
        output in_valid, x_in, out_ready,
        input  y_out, out_valid, overrun
    );

    modport slave (
        input  in_valid, x_in, out_ready,
        output y_out, out_valid, overrun
    );
endinterface

// File: rtl/fir_decim.sv
// Averaging decimator behind a FIR stage: sums N = 1/2/4/8 accepted samples
// and emits the round-half-up average, one result per window.
//   clk     - single rising-edge clock
//   reset   - synchronous, active-high
//   dec_sel - decimation code (0..3 -> N = 1, 2, 4, 8), taken at window start
//   bus     - sample in / result out handshake (fir_decim_if.slave)
module fir_decim #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = DATA_W + 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  dec_sel,
    fir_decim_if.slave  bus
);

    logic [1:0]               n_cur;
    logic [1:0]               win_sel;
    logic [2:0]               cnt;
    logic [2:0]               cnt_last;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  x_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  rnd;
    logic signed [ACC_W-1:0]  sum_rnd;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [DATA_W-1:0] y_next;
    logic signed [DATA_W-1:0] y_q;
    logic                     valid_q;
    logic                     overrun_q;
    logic                     win_done;

    always_comb begin
        // The first sample of a window uses the live dec_sel, so an N==1
        // window both starts and completes on the same sample.
        win_sel  = (cnt == '0) ? dec_sel : n_cur;
        cnt_last = 3'((4'd1 << win_sel) - 4'd1);
        x_ext    = {{(ACC_W-DATA_W){bus.x_in[DATA_W-1]}}, bus.x_in};
        sum      = (cnt == '0) ? x_ext : acc + x_ext;
        rnd      = '0;
        if (win_sel != 2'd0)
            rnd = ACC_W'(1) << (win_sel - 2'd1);
        sum_rnd  = sum + rnd;
        shifted  = sum_rnd >>> win_sel;
        y_next   = shifted[DATA_W-1:0];
        win_done = bus.in_valid && (cnt == cnt_last);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_q       <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            n_cur     <= dec_sel;
        end else begin
            if (bus.in_valid) begin
                acc <= sum;
                cnt <= win_done ? 3'd0 : cnt + 3'd1;
                if (cnt == '0)
                    n_cur <= dec_sel;
            end

            if (win_done) begin
                y_q     <= y_next;
                valid_q <= 1'b1;
                // A consume on the same edge frees the slot, so no overrun.
                if (valid_q && !bus.out_ready)
                    overrun_q <= 1'b1;
            end else if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.y_out     = y_q;
    assign bus.out_valid = valid_q;
    assign bus.overrun   = overrun_q;

endmodule
